pmem_arbiter: RTL

- Arbitrates the single physical-memory port between two line-granular requesters: the instruction cache (port I) and the data cache (port D).
- Sits between the split L1 caches and physical memory. It replaces the direct cache-to-pmem connection when the cache is split.
- Grants one requester at a time and holds the grant until physical memory responds.
- Registers the granted request onto the pmem port and routes the response back only to the granted requester.

---
 rtl/pmem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Shares the single physical-memory port between the split L1 caches.
//   Port I (instruction cache) and port D (data cache) issue line-granular,
//   level-sensitive requests. One requester is granted at a time and keeps
//   the grant until physical memory answers. The granted request is
//   registered onto the pmem port, and the response is routed back only to
//   the granted requester.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   i_pmem_*             I-cache side: read/write/address/wdata in, resp/rdata out
//   d_pmem_*             D-cache side: read/write/address/wdata in, resp/rdata out
//   pmem_read/write      registered strobes toward physical memory
//   pmem_address/wdata   registered address and write line toward physical memory
//   pmem_resp/rdata      completion and read line from physical memory
//
// States
//   IDLE    | no grant; arbitrate among pending requests on each edge
//   GRANT_I | port I owns pmem until pmem_resp
//   GRANT_D | port D owns pmem until pmem_resp
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_pmem_read,
  input  logic                  i_pmem_write,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
  output logic                  i_pmem_resp,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,

  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic                  d_pmem_resp,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state;
  // 0: port I was served last, 1: port D was served last
  logic   last_grant_d;

  logic i_req;
  logic d_req;
  logic pick_i;

  assign i_req = i_pmem_read | i_pmem_write;
  assign d_req = d_pmem_read | d_pmem_write;

  // Under contention the port that was not served last wins, so two
  // continuously requesting caches strictly alternate.
  assign pick_i = i_req & (~d_req | last_grant_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Read and write together is a write.
          if (pick_i) begin
            state        <= GRANT_I;
            pmem_read    <= i_pmem_read & ~i_pmem_write;
            pmem_write   <= i_pmem_write;
            pmem_address <= i_pmem_address;
            pmem_wdata   <= i_pmem_wdata;
          end else if (d_req) begin
            state        <= GRANT_D;
            pmem_read    <= d_pmem_read & ~d_pmem_write;
            pmem_write   <= d_pmem_write;
            pmem_address <= d_pmem_address;
            pmem_wdata   <= d_pmem_wdata;
          end
        end

        GRANT_I, GRANT_D: begin
          // Address and wdata are left as they are; only the strobes drop.
          // Returning to IDLE for one cycle lets the requester retire its
          // request before it can be arbitrated again.
          if (pmem_resp) begin
            state        <= IDLE;
            last_grant_d <= (state == GRANT_D);
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Only combinational paths in the block: memory response to granted port.
  assign i_pmem_resp  = (state == GRANT_I) & pmem_resp;
  assign d_pmem_resp  = (state == GRANT_D) & pmem_resp;
  assign i_pmem_rdata = (state == GRANT_I) ? pmem_rdata : '0;
  assign d_pmem_rdata = (state == GRANT_D) ? pmem_rdata : '0;

endmodule
